// File: rtl/nano_cpu_p.sv
// nano_cpu_p: multi-cycle load/store CPU with a 4-entry register file,
// a 9-opcode ISA and a ready-handshaked memory port. Exports halt status,
// PC and a retired-instruction counter for debug.
module nano_cpu_p #(
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int CNTW = 16
) (
  input  logic            ck,
  input  logic            rst,
  output logic [AW-1:0]   address,
  input  logic [DW-1:0]   dataR,
  output logic [DW-1:0]   dataW,
  output logic            ce,
  output logic            we,
  input  logic            mem_rdy,
  output logic            halted,
  output logic [AW-1:0]   pc,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_LD,
    S_WR,
    S_ALU,
    S_JMP,
    S_BR,
    S_HALT
  } state_t;

  state_t        state;
  logic [DW-1:0] regs [4];
  logic [DW-1:0] ir;
  logic [AW-1:0] pc_q;

  // Instruction fields; bits above 15 never take part in decode.
  logic [3:0]    opcode;
  logic [AW-1:0] ir_addr;
  logic [1:0]    rsel_a;
  logic [1:0]    rsel_b;
  logic [1:0]    rsel_d;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] next_pc;
  logic          retire;
  logic          unused_ir;

  assign opcode    = ir[15:12];
  assign ir_addr   = ir[AW+3:4];
  assign rsel_d    = ir[9:8];
  assign rsel_a    = ir[5:4];
  assign rsel_b    = ir[1:0];
  assign op_a      = regs[rsel_a];
  assign op_b      = regs[rsel_b];
  assign dataW     = op_b;
  assign pc        = pc_q;
  assign pc_inc    = pc_q + AW'(1);
  assign unused_ir = ^ir;

  // ALU datapath: operands are read before the destination is written, so
  // a destination that is also a source sees its old value.
  always_comb begin
    alu_res = '0;
    case (opcode)
      4'h4:    alu_res = op_a ^ op_b;
      4'h5:    alu_res = op_a - op_b;
      4'h6:    alu_res = op_a + op_b;
      4'h7:    alu_res[0] = (op_a < op_b);
      default: alu_res = '0;
    endcase
  end

  // Final-cycle detection and the PC that the retiring instruction leaves.
  always_comb begin
    next_pc = pc_inc;
    retire  = 1'b0;
    case (state)
      S_LD, S_WR: retire = mem_rdy;
      S_ALU:      retire = 1'b1;
      S_JMP: begin
        retire  = 1'b1;
        next_pc = ir_addr;
      end
      S_BR: begin
        retire = 1'b1;
        if (op_b != '0) next_pc = ir_addr;
      end
      default: retire = 1'b0;
    endcase
  end

  // Control FSM with registered memory-port outputs and architectural state.
  // Memory strobes are set on the transition into the access state so ce/we
  // are valid for the whole access without a combinational path from state.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      ir      <= '0;
      retired <= '0;
      address <= '0;
      ce      <= 1'b0;
      we      <= 1'b0;
      halted  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_FETCH;
          ce      <= 1'b1;
          we      <= 1'b0;
          address <= pc_q;
        end
        S_FETCH: begin
          if (mem_rdy) begin
            ir    <= dataR;
            state <= S_EXEC;
            ce    <= 1'b0;
          end
        end
        S_EXEC: begin
          address <= ir_addr;
          case (opcode)
            4'h0: begin
              state <= S_LD;
              ce    <= 1'b1;
            end
            4'h1: begin
              state <= S_WR;
              ce    <= 1'b1;
              we    <= 1'b1;
            end
            4'h2:                   state <= S_JMP;
            4'h3:                   state <= S_BR;
            4'h4, 4'h5, 4'h6, 4'h7: state <= S_ALU;
            default: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          endcase
        end
        S_LD, S_WR, S_ALU, S_JMP, S_BR: begin
          if (retire) begin
            if (state == S_LD)  regs[rsel_b] <= dataR;
            if (state == S_ALU) regs[rsel_d] <= alu_res;
            pc_q    <= next_pc;
            retired <= retired + CNTW'(1);
            state   <= S_FETCH;
            ce      <= 1'b1;
            we      <= 1'b0;
            address <= next_pc;
          end
        end
        S_HALT: begin
          halted <= 1'b1;
          ce     <= 1'b0;
          we     <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          ce    <= 1'b0;
          we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nano_cpu_p.sv
// tb_nano_cpu_p: drives nano_cpu_p from a behavioural memory and compares
// every memory access, PC, retired count and halt against an ISA-level model.
module tb_nano_cpu_p;
  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int CNTW = 16;
  localparam logic [15:0] END_I = 16'hF000;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  int cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  // main instance: DW=16, AW=8, CNTW=16
  logic            rst = 1'b1;
  logic [AW-1:0]   address, pc;
  logic [DW-1:0]   dataR = '0, dataW;
  logic            ce, we, halted;
  logic            mem_rdy = 1'b0;
  logic [CNTW-1:0] retired;

  nano_cpu_p #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
    .ck(ck), .rst(rst), .address(address), .dataR(dataR), .dataW(dataW),
    .ce(ce), .we(we), .mem_rdy(mem_rdy), .halted(halted), .pc(pc),
    .retired(retired)
  );

  // small instance: DW=32, AW=4, CNTW=4, zero-wait memory
  logic        rst2 = 1'b1;
  logic [3:0]  address2, pc2, retired2;
  logic [31:0] dataR2, dataW2;
  logic        ce2, we2, halted2;
  logic [31:0] mem2 [16];
  assign dataR2 = mem2[address2];

  nano_cpu_p #(.DW(32), .AW(4), .CNTW(4)) dut2 (
    .ck(ck), .rst(rst2), .address(address2), .dataR(dataR2), .dataW(dataW2),
    .ce(ce2), .we(we2), .mem_rdy(1'b1), .halted(halted2), .pc(pc2),
    .retired(retired2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // bench memory serving the DUT, and the model's own view of memory/state
  logic [DW-1:0]   mem [256];
  logic [DW-1:0]   mm  [256];
  logic [DW-1:0]   mr  [4];
  logic [AW-1:0]   mpc;
  logic [CNTW-1:0] mret;
  int              wmode = 0;   // wait cycles per access, -1 = random 0..3
  int              t_seen;
  bit              stuck;
  int              hits9;
  int              span;
  bit              found;

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [7:0] a, input logic [1:0] r);
    return {op, a, 2'b00, r};
  endfunction

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [1:0] d,
                                      input logic [1:0] s1, input logic [1:0] s2);
    return {op, 2'b00, d, 2'b00, s1, 2'b00, s2};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_rdy = 1'b0;
    @(negedge ck);
    #1;
    check("rst_ce", 64'(ce), 64'(0));
    check("rst_we", 64'(we), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_pc", 64'(pc), 64'(0));
    check("rst_retired", 64'(retired), 64'(0));
    @(negedge ck);
    rst = 1'b0;
  endtask

  // Wait for the DUT to request memory, check the request, insert waits,
  // then complete it. Entered and left on a falling edge.
  task automatic access(input logic [AW-1:0] ea, input logic ewe, input logic [DW-1:0] ed,
                        input int gap_exp, input string tag);
    int gap = 0;
    int w;
    while (!ce && gap < 8) begin
      @(negedge ck);
      gap++;
    end
    check({tag, "_gap"}, 64'(gap), 64'(gap_exp));
    if (!ce) begin
      stuck = 1'b1;
      return;
    end
    t_seen = cyc;
    check({tag, "_addr"}, 64'(address), 64'(ea));
    check({tag, "_we"}, 64'(we), 64'(ewe));
    if (ewe) check({tag, "_data"}, 64'(dataW), 64'(ed));
    if (tag == "fetch" && address == 8'h09) hits9++;
    w = (wmode < 0) ? int'($urandom_range(0, 3)) : wmode;
    for (int i = 0; i < w; i++) begin
      mem_rdy = 1'b0;
      @(negedge ck);
      check({tag, "_hold_ce"}, 64'(ce), 64'(1));
      if (ewe) begin
        check({tag, "_hold_addr"}, 64'(address), 64'(ea));
        check({tag, "_hold_we"}, 64'(we), 64'(1));
        check({tag, "_hold_data"}, 64'(dataW), 64'(ed));
      end
    end
    mem_rdy = 1'b1;
    dataR = mem[address];
    if (we) mem[address] = dataW;
    @(negedge ck);
    mem_rdy = 1'b0;
  endtask

  // ISA-level model: executes instruction by instruction from its own copy
  // of memory and predicts every access the DUT must make.
  task automatic run_program(input int max_instr, input int first_gap, output int span_o);
    int            gap = first_gap;
    int            t_first = 0;
    logic [15:0]   ins;
    logic [3:0]    op;
    logic [AW-1:0] fa;
    logic [1:0]    rb, ra, rd;
    logic [DW-1:0] x, y;
    for (int i = 0; i < 256; i++) mm[i] = mem[i];
    for (int i = 0; i < 4; i++) mr[i] = '0;
    mpc = '0;
    mret = '0;
    stuck = 1'b0;
    span_o = -1;
    for (int n = 0; n < max_instr && !stuck; n++) begin
      access(mpc, 1'b0, '0, gap, "fetch");
      if (stuck) break;
      if (n == 0) t_first = t_seen;
      check("pc", 64'(pc), 64'(mpc));
      check("retired", 64'(retired), 64'(mret));
      ins = mm[mpc];
      op = ins[15:12];
      fa = ins[AW+3:4];
      rb = ins[1:0];
      ra = ins[5:4];
      rd = ins[9:8];
      x = mr[ra];
      y = mr[rb];
      gap = 2;
      case (op)
        4'h0: begin
          access(fa, 1'b0, '0, 1, "ld");
          mr[rb] = mm[fa];
          gap = 0;
          mpc++;
        end
        4'h1: begin
          access(fa, 1'b1, y, 1, "wr");
          mm[fa] = y;
          gap = 0;
          mpc++;
        end
        4'h2: mpc = fa;
        4'h3: mpc = (y != '0) ? fa : mpc + AW'(1);
        4'h4: begin mr[rd] = x ^ y;        mpc++; end
        4'h5: begin mr[rd] = x - y;        mpc++; end
        4'h6: begin mr[rd] = x + y;        mpc++; end
        4'h7: begin mr[rd] = DW'(x < y);   mpc++; end
        default: begin
          check("halted_exec", 64'(halted), 64'(0));
          @(negedge ck);
          check("halted", 64'(halted), 64'(1));
          check("ce_halt", 64'(ce), 64'(0));
          // index of the END decode cycle, first FETCH cycle = 0
          span_o = cyc - t_first - 1;
          repeat (3) @(negedge ck);
          check("halt_stays", 64'(halted), 64'(1));
          check("halt_pc", 64'(pc), 64'(mpc));
          check("halt_retired", 64'(retired), 64'(mret));
          break;
        end
      endcase
      mret++;
    end
  endtask

  task automatic load_sum_prog();
    clear_mem();
    mem[0] = mk(4'h0, 8'h10, 2'd0);
    mem[1] = mk(4'h0, 8'h11, 2'd1);
    mem[2] = alu(4'h6, 2'd2, 2'd0, 2'd1);
    mem[3] = mk(4'h1, 8'h12, 2'd2);
    mem[4] = END_I;
    mem[8'h10] = 16'd5;
    mem[8'h11] = 16'd7;
  endtask

  task automatic gen_random();
    clear_mem();
    for (int a = 0; a < 24; a++) begin
      int unsigned op;
      logic [7:0]  t;
      op = $urandom_range(0, 8);
      if (op <= 1) t = 8'h80 | 8'($urandom_range(0, 127));
      else         t = 8'($urandom_range(0, 24));
      if (op == 8)      mem[a] = END_I;
      else if (op >= 4) mem[a] = alu(4'(op), 2'($urandom), 2'($urandom), 2'($urandom));
      else              mem[a] = mk(4'(op), t, 2'($urandom));
    end
    mem[24] = END_I;
    for (int a = 128; a < 256; a++) mem[a] = 16'($urandom);
  endtask

  task automatic run_small();
    bit ok;
    for (int i = 0; i < 16; i++) mem2[i] = '0;
    mem2[0]  = {16'h0, mk(4'h0, 8'h0D, 2'd0)};
    mem2[1]  = {16'h0, mk(4'h0, 8'h0E, 2'd1)};
    mem2[2]  = {16'h0, alu(4'h6, 2'd2, 2'd0, 2'd1)};
    mem2[3]  = {16'h0, mk(4'h1, 8'h0C, 2'd2)};
    mem2[4]  = {16'h0, mk(4'h2, 8'h0F, 2'd0)};
    mem2[15] = {16'h0, alu(4'h6, 2'd3, 2'd0, 2'd1)};
    mem2[12] = 32'hDEAD_BEEF;
    mem2[13] = 32'hFFFF_FFFF;
    mem2[14] = 32'h0000_0001;
    rst2 = 1'b1;
    @(negedge ck);
    @(negedge ck);
    rst2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge ck);
      if (ce2 && we2) ok = 1'b1;
    end
    check("w32_seen", 64'(ok), 64'(1));
    check("w32_addr", 64'(address2), 64'(4'hC));
    check("w32_add_wrap", 64'(dataW2), 64'(0));
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge ck);
      if (ce2 && !we2 && address2 == 4'hF) ok = 1'b1;
    end
    check("aw4_fetch_f", 64'(ok), 64'(1));
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge ck);
      if (ce2) ok = 1'b1;
    end
    check("aw4_wrap_addr", 64'(address2), 64'(0));
    check("aw4_wrap_pc", 64'(pc2), 64'(0));
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge ck);
      if (retired2 == 4'd15) ok = 1'b1;
    end
    check("cnt_reach15", 64'(ok), 64'(1));
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge ck);
      if (retired2 != 4'd15) ok = 1'b1;
    end
    check("cnt_wrap", 64'(retired2), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge ck);

    // zero-wait arithmetic program
    wmode = 0;
    load_sum_prog();
    do_reset();
    run_program(20, 1, span);
    check("s1_mem12", 64'(mem[8'h12]), 64'(12));
    check("s1_retired", 64'(retired), 64'(4));
    check("s1_span", 64'(span), 64'(13));

    // same program, two wait cycles on every access
    wmode = 2;
    load_sum_prog();
    do_reset();
    run_program(20, 1, span);
    check("w2_mem12", 64'(mem[8'h12]), 64'(12));
    check("w2_span", 64'(span), 64'(13 + 8 * 2));
    wmode = 0;

    // ALU operations
    clear_mem();
    mem[0]  = mk(4'h0, 8'h10, 2'd0);
    mem[1]  = mk(4'h0, 8'h11, 2'd1);
    mem[2]  = alu(4'h4, 2'd2, 2'd0, 2'd1);
    mem[3]  = mk(4'h1, 8'h20, 2'd2);
    mem[4]  = alu(4'h5, 2'd2, 2'd0, 2'd1);
    mem[5]  = mk(4'h1, 8'h21, 2'd2);
    mem[6]  = alu(4'h7, 2'd2, 2'd1, 2'd0);
    mem[7]  = mk(4'h1, 8'h22, 2'd2);
    mem[8]  = alu(4'h7, 2'd2, 2'd0, 2'd1);
    mem[9]  = mk(4'h1, 8'h23, 2'd2);
    mem[10] = alu(4'h6, 2'd0, 2'd0, 2'd0);
    mem[11] = mk(4'h1, 8'h24, 2'd0);
    mem[12] = END_I;
    mem[8'h10] = 16'h00F0;
    mem[8'h11] = 16'h0F0F;
    do_reset();
    run_program(30, 1, span);
    check("alu_xor", 64'(mem[8'h20]), 64'(16'h0FFF));
    check("alu_sub", 64'(mem[8'h21]), 64'(16'hF1E1));
    check("alu_less_r1r0", 64'(mem[8'h22]), 64'(0));
    check("alu_less_r0r1", 64'(mem[8'h23]), 64'(1));
    check("alu_dst_is_src", 64'(mem[8'h24]), 64'(16'h01E0));

    // branches, jump and a count-down loop
    clear_mem();
    mem[0]  = mk(4'h3, 8'h20, 2'd3);
    mem[1]  = mk(4'h0, 8'h40, 2'd3);
    mem[2]  = mk(4'h3, 8'h20, 2'd3);
    mem[8'h20] = mk(4'h2, 8'h05, 2'd0);
    mem[5]  = mk(4'h0, 8'h41, 2'd0);
    mem[6]  = mk(4'h0, 8'h40, 2'd1);
    mem[7]  = mk(4'h3, 8'h09, 2'd0);
    mem[8]  = END_I;
    mem[9]  = alu(4'h5, 2'd0, 2'd0, 2'd1);
    mem[10] = mk(4'h2, 8'h07, 2'd0);
    mem[8'h40] = 16'd1;
    mem[8'h41] = 16'd3;
    hits9 = 0;
    do_reset();
    run_program(40, 1, span);
    check("loop_taken", 64'(hits9), 64'(3));
    check("loop_exit_pc", 64'(pc), 64'(8));

    // random programs, random wait states
    wmode = -1;
    for (int p = 0; p < 8; p++) begin
      gen_random();
      do_reset();
      run_program(60, 1, span);
    end
    wmode = 0;

    // reset asserted while a load is waiting for memory
    clear_mem();
    mem[0] = mk(4'h2, 8'h03, 2'd0);
    mem[3] = mk(4'h0, 8'h10, 2'd0);
    mem[8'h10] = 16'hABCD;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge ck);
      if (ce && address == 8'h10) found = 1'b1;
      else begin
        mem_rdy = ce;
        dataR = mem[address];
      end
    end
    mem_rdy = 1'b0;
    check("mid_ld_seen", 64'(found), 64'(1));
    @(negedge ck);
    check("mid_pre_pc", 64'(pc), 64'(3));
    check("mid_pre_retired", 64'(retired), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_ce", 64'(ce), 64'(0));
    check("mid_we", 64'(we), 64'(0));
    check("mid_pc", 64'(pc), 64'(0));
    check("mid_retired", 64'(retired), 64'(0));
    check("mid_halted", 64'(halted), 64'(0));
    @(negedge ck);
    rst = 1'b0;
    #1;
    check("post_rst_idle_ce", 64'(ce), 64'(0));
    @(negedge ck);
    check("post_rst_fetch_ce", 64'(ce), 64'(1));
    check("post_rst_fetch_addr", 64'(address), 64'(0));
    mem[0] = mk(4'h1, 8'h30, 2'd0);
    mem[1] = END_I;
    mem[8'h30] = 16'h5555;
    run_program(10, 0, span);
    check("mid_r0_cleared", 64'(mem[8'h30]), 64'(0));

    // parameter variation instance
    run_small();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
